// File: rtl/axil_reg_bank.sv
// rtl/axil_reg_bank.sv - AXI4-Lite register bank with read/write control and read-only status registers
// Optional macro AXIL_REG_DECERR_EN: DECERR for out-of-range accesses, SLVERR for writes to read-only registers.
module axil_reg_bank #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    AXIL_WIDTH      = 32,
    parameter int                    AXIL_STRB_WIDTH = AXIL_WIDTH / 8,
    parameter logic [ADDR_WIDTH-1:0] AXIL_BASE_ADDR  = '0,
    parameter int                    NUM_REGS        = 16,
    parameter logic [NUM_REGS-1:0]   RO_MASK         = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          s_axil_awaddr,
    input  logic [2:0]                     s_axil_awprot,
    input  logic                           s_axil_awvalid,
    output logic                           s_axil_awready,
    input  logic [AXIL_WIDTH-1:0]          s_axil_wdata,
    input  logic [AXIL_STRB_WIDTH-1:0]     s_axil_wstrb,
    input  logic                           s_axil_wvalid,
    output logic                           s_axil_wready,
    output logic [1:0]                     s_axil_bresp,
    output logic                           s_axil_bvalid,
    input  logic                           s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axil_araddr,
    input  logic [2:0]                     s_axil_arprot,
    input  logic                           s_axil_arvalid,
    output logic                           s_axil_arready,
    output logic [AXIL_WIDTH-1:0]          s_axil_rdata,
    output logic [1:0]                     s_axil_rresp,
    output logic                           s_axil_rvalid,
    input  logic                           s_axil_rready,
    output logic [NUM_REGS*AXIL_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr,
    input  logic [NUM_REGS*AXIL_WIDTH-1:0] sts_in
);
    localparam int ADDR_LSB = $clog2(AXIL_STRB_WIDTH);
    localparam int IDX_W    = $clog2(NUM_REGS);

    typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t                       w_state_q, w_state_d;
    r_state_t                       r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0]          awaddr_q, awaddr_d;
    logic [AXIL_WIDTH-1:0]          wdata_q, wdata_d;
    logic [AXIL_STRB_WIDTH-1:0]     wstrb_q, wstrb_d;
    logic [NUM_REGS*AXIL_WIDTH-1:0] reg_q_q, reg_q_d;
    logic [NUM_REGS-1:0]            reg_wr_q, reg_wr_d;
    logic [1:0]                     bresp_q, bresp_d, rresp_q, rresp_d;
    logic [AXIL_WIDTH-1:0]          rdata_q, rdata_d;

    logic                       aw_hs, w_hs, commit;
    logic [ADDR_WIDTH-1:0]      c_addr;
    logic [AXIL_WIDTH-1:0]      c_data;
    logic [AXIL_STRB_WIDTH-1:0] c_strb;
    logic                       w_hit, w_ro, r_hit;
    logic [IDX_W-1:0]           w_idx, r_idx;
    logic                       unused_prot;

    assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

    function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >= AXIL_BASE_ADDR) &&
               (((addr - AXIL_BASE_ADDR) >> ADDR_LSB) < ADDR_WIDTH'(NUM_REGS));
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_W'((addr - AXIL_BASE_ADDR) >> ADDR_LSB);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            reg_q_q   <= '0;
            reg_wr_q  <= '0;
            bresp_q   <= 2'b00;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            reg_q_q   <= reg_q_d;
            reg_wr_q  <= reg_wr_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        aw_hs  = s_axil_awvalid && s_axil_awready;
        w_hs   = s_axil_wvalid && s_axil_wready;
        // Each half of the write comes from its holding register once captured, else from the live bus
        c_addr = (w_state_q == W_HAVE_A) ? awaddr_q : s_axil_awaddr;
        c_data = (w_state_q == W_HAVE_D) ? wdata_q : s_axil_wdata;
        c_strb = (w_state_q == W_HAVE_D) ? wstrb_q : s_axil_wstrb;
        w_hit  = addr_hit(c_addr);
        w_idx  = addr_idx(c_addr);
        w_ro   = w_hit && RO_MASK[w_idx];
        commit = (aw_hs || w_state_q == W_HAVE_A) && (w_hs || w_state_q == W_HAVE_D);

        w_state_d = w_state_q;
        awaddr_d  = aw_hs ? s_axil_awaddr : awaddr_q;
        wdata_d   = w_hs ? s_axil_wdata : wdata_q;
        wstrb_d   = w_hs ? s_axil_wstrb : wstrb_q;
        reg_q_d   = reg_q_q;
        reg_wr_d  = '0;
        bresp_d   = bresp_q;

        if (commit) begin
            w_state_d = W_RESP;
`ifdef AXIL_REG_DECERR_EN
            bresp_d = !w_hit ? 2'b11 : (w_ro ? 2'b10 : 2'b00);
`else
            bresp_d = 2'b00;
`endif
            if (w_hit && !w_ro) begin
                reg_wr_d[w_idx] = 1'b1;
                for (int b = 0; b < AXIL_STRB_WIDTH; b++) begin
                    if (c_strb[b]) begin
                        reg_q_d[w_idx*AXIL_WIDTH + 8*b +: 8] = c_data[8*b +: 8];
                    end
                end
            end
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_hs)     w_state_d = W_HAVE_A;
                    else if (w_hs) w_state_d = W_HAVE_D;
                end
                W_RESP: if (s_axil_bready) w_state_d = W_IDLE;
                default: ;
            endcase
        end

        // Reads sample reg_q_q, so a same-cycle write is not yet visible
        r_hit     = addr_hit(s_axil_araddr);
        r_idx     = addr_idx(s_axil_araddr);
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (s_axil_arvalid) begin
                    r_state_d = R_RESP;
                    rdata_d   = '0;
                    if (r_hit) begin
                        rdata_d = RO_MASK[r_idx] ? sts_in[r_idx*AXIL_WIDTH +: AXIL_WIDTH]
                                                 : reg_q_q[r_idx*AXIL_WIDTH +: AXIL_WIDTH];
                    end
`ifdef AXIL_REG_DECERR_EN
                    rresp_d = r_hit ? 2'b00 : 2'b11;
`else
                    rresp_d = 2'b00;
`endif
                end
            end
            R_RESP: if (s_axil_rready) r_state_d = R_IDLE;
            default: ;
        endcase
    end

    always_comb begin
        s_axil_awready = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_D);
        s_axil_wready  = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_A);
        s_axil_bvalid  = (w_state_q == W_RESP);
        s_axil_bresp   = bresp_q;
        s_axil_arready = (r_state_q == R_IDLE);
        s_axil_rvalid  = (r_state_q == R_RESP);
        s_axil_rdata   = rdata_q;
        s_axil_rresp   = rresp_q;
        reg_q          = reg_q_q;
        reg_wr         = reg_wr_q;
    end
endmodule

// File: tb/tb_axil_reg_bank.sv
// tb/tb_axil_reg_bank.sv - directed self-checking bench for axil_reg_bank
module tb_axil_reg_bank;
    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam int          SW   = 4;
    localparam int          NR   = 16;
    localparam logic [31:0] BASE = 32'h100;
`ifdef AXIL_REG_DECERR_EN
    localparam logic [1:0] EXP_DEC = 2'b11;
    localparam logic [1:0] EXP_SLV = 2'b10;
`else
    localparam logic [1:0] EXP_DEC = 2'b00;
    localparam logic [1:0] EXP_SLV = 2'b00;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0] awprot, arprot;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic [1:0] bresp, rresp;
    logic [NR*DW-1:0] reg_q, sts_in;
    logic [NR-1:0] reg_wr;

    int n_checks = 0;
    int n_pass = 0;
    int wr_cnt[NR];

    axil_reg_bank #(
        .ADDR_WIDTH(AW), .AXIL_WIDTH(DW), .AXIL_STRB_WIDTH(SW),
        .AXIL_BASE_ADDR(BASE), .NUM_REGS(NR), .RO_MASK(16'h0004)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .reg_q(reg_q), .reg_wr(reg_wr), .sts_in(sts_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) if (reg_wr[i]) wr_cnt[i]++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] reg_val(input int i);
        return reg_q[i*DW +: DW];
    endfunction

    function automatic int wr_total();
        int s = 0;
        for (int i = 0; i < NR; i++) s += wr_cnt[i];
        return s;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp);
        int n;
        bit a_done, d_done, a_fire, d_fire;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        a_done = 0; d_done = 0; n = 0;
        while (!(a_done && d_done) && n < 20) begin
            a_fire = awvalid && awready;
            d_fire = wvalid && wready;
            tick();
            n++;
            if (a_fire) begin a_done = 1; awvalid = 1'b0; end
            if (d_fire) begin d_done = 1; wvalid = 1'b0; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        check("wr_bvalid", bvalid, 1'b1);
        resp = bresp;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        bit fire;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0; fire = 0;
        while (!fire && n < 20) begin
            fire = arready;
            tick();
            n++;
        end
        arvalid = 1'b0;
        check("rd_latency", rvalid, 1'b1);
        n = 0;
        while (!rvalid && n < 20) begin tick(); n++; end
        data = rdata;
        resp = rresp;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        int c0;
        rst = 1'b1;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        wdata = '0; wstrb = '0;
        sts_in = '0;
        sts_in[2*DW +: DW] = 32'h5A5A_0001;
        sts_in[1*DW +: DW] = 32'hFFFF_0000;
        tick(); tick();
        check("rst_awready", awready, 1'b1);
        check("rst_wready", wready, 1'b1);
        check("rst_arready", arready, 1'b1);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_reg_q_any", |reg_q, 1'b0);
        check("rst_reg_wr", reg_wr, 16'h0);
        rst = 1'b0;
        tick();

        axi_write(BASE + 32'h4, 32'hDEAD_BEEF, 4'hF, resp);
        check("t1_bresp", resp, 2'b00);
        check("t1_reg1", reg_val(1), 32'hDEAD_BEEF);
        check("t1_wr_cnt1", wr_cnt[1], 1);
        axi_read(BASE + 32'h4, rd, resp);
        check("t1_rdata", rd, 32'hDEAD_BEEF);
        check("t1_rresp", resp, 2'b00);
        axi_read(BASE + 32'h7, rd, resp);
        check("t1_rdata_offset", rd, 32'hDEAD_BEEF);

        // W three cycles ahead of AW
        c0 = wr_cnt[4];
        wdata = 32'hCAFE_0004; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("t2_wready_low", wready, 1'b0);
        check("t2_awready_high", awready, 1'b1);
        check("t2_no_bvalid", bvalid, 1'b0);
        tick(); tick();
        awaddr = BASE + 32'h10; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("t2_bvalid", bvalid, 1'b1);
        check("t2_reg4", reg_val(4), 32'hCAFE_0004);
        tick(); tick();
        check("t2_bvalid_hold", bvalid, 1'b1);
        check("t2_awready_low", awready, 1'b0);
        check("t2_wready_low_b", wready, 1'b0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("t2_bvalid_done", bvalid, 1'b0);
        check("t2_awready_back", awready, 1'b1);
        check("t2_wready_back", wready, 1'b1);
        check("t2_wr_cnt4", wr_cnt[4] - c0, 1);

        c0 = wr_cnt[5];
        axi_write(BASE + 32'h14, 32'h0BAD_F00D, 4'hF, resp);
        check("t2s_bresp", resp, 2'b00);
        check("t2s_reg5", reg_val(5), 32'h0BAD_F00D);
        check("t2s_wr_cnt5", wr_cnt[5] - c0, 1);

        axi_write(BASE + 32'hC, 32'h1122_3344, 4'hF, resp);
        axi_write(BASE + 32'hC, 32'hAABB_CCDD, 4'h5, resp);
        axi_read(BASE + 32'hC, rd, resp);
        check("t3_strb_merge", rd, 32'h11BB_33DD);

        axi_read(BASE + 32'h8, rd, resp);
        check("t4_ro_rdata", rd, 32'h5A5A_0001);
        c0 = wr_total();
        axi_write(BASE + 32'h8, 32'h1234_5678, 4'hF, resp);
        check("t4_ro_bresp", resp, EXP_SLV);
        check("t4_ro_reg_q", reg_val(2), 32'h0);
        check("t4_ro_no_wr", wr_total() - c0, 0);
        axi_read(BASE + 32'h8, rd, resp);
        check("t4_ro_rdata2", rd, 32'h5A5A_0001);

        c0 = wr_total();
        axi_write(BASE - 32'h4, 32'h9999_9999, 4'hF, resp);
        check("t5_below_bresp", resp, EXP_DEC);
        axi_write(BASE + 32'h40, 32'h8888_8888, 4'hF, resp);
        check("t5_above_bresp", resp, EXP_DEC);
        check("t5_oor_no_wr", wr_total() - c0, 0);
        axi_write(BASE + 32'h3C, 32'h0F0F_0F0F, 4'hF, resp);
        axi_read(BASE + 32'h3C, rd, resp);
        check("t5_last_reg", rd, 32'h0F0F_0F0F);

        // Out-of-range read held with rready low; a new AR must not be taken
        araddr = BASE + 32'h40; arvalid = 1'b1; rready = 1'b0;
        tick();
        araddr = BASE + 32'h4;
        check("t5_rvalid", rvalid, 1'b1);
        check("t5_rdata_zero", rdata, 32'h0);
        check("t5_rresp", rresp, EXP_DEC);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_hold_rvalid", rvalid, 1'b1);
            check("t5_hold_rdata", rdata, 32'h0);
            check("t5_hold_arready", arready, 1'b0);
        end
        arvalid = 1'b0; rready = 1'b1;
        tick();
        rready = 1'b0;
        check("t5_rvalid_done", rvalid, 1'b0);
        check("t5_arready_back", arready, 1'b1);

        // Read and write hit register 5 on the same edge
        awaddr = BASE + 32'h14; wdata = 32'h0000_0002; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = BASE + 32'h14; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("t6_rd_prewrite", rdata, 32'h0BAD_F00D);
        check("t6_reg5_new", reg_val(5), 32'h0000_0002);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;

        // Reset with B and R responses outstanding
        awaddr = BASE + 32'h18; wdata = 32'h66; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = BASE + 32'h4; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("t7_pre_bvalid", bvalid, 1'b1);
        check("t7_pre_rvalid", rvalid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t7_bvalid", bvalid, 1'b0);
        check("t7_rvalid", rvalid, 1'b0);
        check("t7_awready", awready, 1'b1);
        check("t7_wready", wready, 1'b1);
        check("t7_arready", arready, 1'b1);
        check("t7_reg_q_any", |reg_q, 1'b0);

        // AW captured, then reset: a later lone W must not complete the old write
        awaddr = BASE + 32'h18; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wdata = 32'h77; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        tick();
        check("t7_no_partial_bvalid", bvalid, 1'b0);
        check("t7_no_partial_reg6", reg_val(6), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/axil_reg_bank.md
Name: axil_reg_bank

Overview:
- AXI4-Lite responder (slave) register bank. Terminates the host-side s_axil_* control port driven by the AXI-Lite initiator.
- Exposes NUM_REGS word registers to the accelerator core. Each register is either read/write (control) or read-only (status).
- Sits inside the top-level integration wrapper, between the s_axil_* port and the DMA/core control logic.

Parameters:
- ADDR_WIDTH, 32, AXI-Lite address width.
- AXIL_WIDTH, 32, data width; must be 32 or 64.
- AXIL_STRB_WIDTH, AXIL_WIDTH/8, write strobe width.
- AXIL_BASE_ADDR, 'h0, byte address of register 0.
- NUM_REGS, 16, number of registers; must be ≥2.
- RO_MASK, 'h0, NUM_REGS bits; bit i=1 makes register i read-only (reads come from sts_in).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axil_awaddr  in  ADDR_WIDTH  write address
- s_axil_awprot  in  3  ignored
- s_axil_awvalid  in  1
- s_axil_awready  out  1
- s_axil_wdata  in  AXIL_WIDTH
- s_axil_wstrb  in  AXIL_STRB_WIDTH
- s_axil_wvalid  in  1
- s_axil_wready  out  1
- s_axil_bresp  out  2
- s_axil_bvalid  out  1
- s_axil_bready  in  1
- s_axil_araddr  in  ADDR_WIDTH
- s_axil_arprot  in  3  ignored
- s_axil_arvalid  in  1
- s_axil_arready  out  1
- s_axil_rdata  out  AXIL_WIDTH
- s_axil_rresp  out  2
- s_axil_rvalid  out  1
- s_axil_rready  in  1
- reg_q  out  NUM_REGS*AXIL_WIDTH  current register contents; register i at bits [i*AXIL_WIDTH +: AXIL_WIDTH]
- reg_wr  out  NUM_REGS  one-cycle pulse the cycle after register i is written
- sts_in  in  NUM_REGS*AXIL_WIDTH  status values for RO_MASK registers; other slices unused

Behaviour:
- Reset (rst=1 at posedge): all reg_q=0, reg_wr=0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0. awready=1, wready=1, arready=1.
- Index = (addr - AXIL_BASE_ADDR) >> log2(AXIL_STRB_WIDTH). Low byte-offset bits are ignored. Address is in range iff addr ≥ AXIL_BASE_ADDR and index < NUM_REGS.
- Write FSM states: W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP.
  - AW and W are accepted independently, each latched into a one-entry holding register. A channel's ready drops after its beat is captured.
  - Both captured, in either order or in the same cycle: commit the write, go to W_RESP, bvalid=1 on the next cycle.
  - Commit: for each byte b with wstrb[b]=1, reg_q[idx][8b+:8] <= wdata[8b+:8]. reg_wr[idx] pulses once in the cycle after the commit.
  - Write to an RO register or an out-of-range address: no state change, no reg_wr pulse.
  - bvalid is held until bready. On handshake, awready=wready=1 the next cycle and the FSM returns to W_IDLE.
  - At most one outstanding write.
- Read FSM states: R_IDLE, R_RESP.
  - AR handshake in R_IDLE: arready drops; rdata is registered, rvalid=1 on the next cycle (1-cycle latency).
  - rdata = reg_q[idx] for RW registers, sts_in slice for RO registers, 0 for out of range.
  - rdata and rresp are held stable while rvalid && !rready. On handshake, arready=1 the next cycle.
- Read and write channels are fully independent. If a read and a write target the same register in the same cycle, the read returns the pre-write value.
- bresp/rresp: OKAY (2'b00) unless the optional feature applies.
- Reset mid-transaction: pending AW/W/AR beats are discarded, outstanding bvalid/rvalid drop the cycle after rst, and no partial write is committed.

Optional Feature:
- Macro: AXIL_REG_DECERR_EN.
- Defined: out-of-range accesses return DECERR (2'b11), and writes to RO registers return SLVERR (2'b10).
- Undefined: all responses are OKAY; the silent drop/zero-read behaviour is unchanged.

Test Plan:
- Write 0xDEADBEEF to base+0x4 with wstrb=0xF, then read base+0x4: bresp=0, rdata=0xDEADBEEF, reg_wr[1] pulses exactly once.
- W beat issued 3 cycles before AW, and separately both in the same cycle: exactly one commit per transaction, one B response each, awready/wready low until the B handshake completes.
- Write 0x11223344 then 0xAABBCCDD with wstrb=0x5: register reads 0x11BB33DD.
- Read RO register 2 with sts_in slice=0x5A5A0001: rdata=0x5A5A0001. Write to it: value unchanged, no reg_wr pulse, bresp=2'b10 with the macro else 2'b00.
- Read at base+4*NUM_REGS: rdata=0, rresp=2'b11 with the macro else 0. Hold rready=0 for 5 cycles: rvalid/rdata stable, no new AR accepted.
- Assert rst while bvalid=1 and an AR is pending: next cycle bvalid=rvalid=0, all readies=1, reg_q=0.
